// File: rtl/panel_pkg.sv
// Shared definitions for the lathe operator panel conditioner: FSM state
// encoding and the default debounce interval.
package panel_pkg;

  // Default number of consecutive enabled cycles an input must hold before
  // its debounced value follows it.
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Panel FSM states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } panel_state_e;

endpackage

// File: rtl/lathe_panel_cond_if.sv
// Operator panel bundle: raw panel contacts and clock enable towards the
// conditioner, conditioned levels and FSM state back out.
// master = panel / stimulus side, slave = lathe_panel_cond.
interface lathe_panel_cond_if;
  logic       ena;
  logic       btn_start;
  logic       btn_stop;
  logic       sel_auto;
  logic       sel_man;
  logic       estop_n;
  logic       start_o;
  logic       auto_o;
  logic       man_o;
  logic       fault_o;
  logic [1:0] state_o;

  modport master (
    output ena, btn_start, btn_stop, sel_auto, sel_man, estop_n,
    input  start_o, auto_o, man_o, fault_o, state_o
  );

  modport slave (
    input  ena, btn_start, btn_stop, sel_auto, sel_man, estop_n,
    output start_o, auto_o, man_o, fault_o, state_o
  );
endinterface

// File: rtl/panel_debounce.sv
// Single-input debouncer: the output follows the input only after the input
// has differed from it for DEBOUNCE_CYCLES consecutive enabled cycles.
module panel_debounce
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ena_i,
  input  logic din_i,
  output logic dout_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          debounced_q, debounced_d;

  // Count disagreeing cycles; any agreement restarts the interval, and the
  // final disagreeing cycle flips the output and restarts the counter.
  always_comb begin
    cnt_d       = cnt_q;
    debounced_d = debounced_q;
    if (ena_i) begin
      if (din_i == debounced_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        cnt_d       = '0;
        debounced_d = ~debounced_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and debounced level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      debounced_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
    end
  end

  assign dout_o = debounced_q;

endmodule

// File: rtl/lathe_panel_cond.sv
// Lathe operator panel conditioner: debounces start/stop buttons and the
// AUTO/MAN selector, and runs the IDLE/RUN/FAULT seal-in FSM that drives the
// start level to the downstream control stage.
// Optional macro PANEL_SYNC_EN: adds a 2-flop synchroniser on every raw
// input ahead of the debouncers and the e-stop logic.
module lathe_panel_cond
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  lathe_panel_cond_if.slave pnl
);

  // E-stop is carried inverted (active high) so that cleared synchroniser
  // flops after reset read as "no e-stop" instead of tripping FAULT.
  logic [4:0] raw;
  logic [4:0] cond;

  assign raw = {~pnl.estop_n, pnl.sel_man, pnl.sel_auto, pnl.btn_stop, pnl.btn_start};

`ifdef PANEL_SYNC_EN
  logic [4:0] sync1_q, sync2_q;

  // Two-stage synchroniser; free-running so e-stop works with ena low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign cond = sync2_q;
`else
  assign cond = raw;
`endif

  logic dStart, dStop, dAuto, dMan;
  logic estopAct;

  assign estopAct = cond[4];

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebStart (
    .clk(clk), .reset(reset), .ena_i(pnl.ena), .din_i(cond[0]), .dout_o(dStart)
  );

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebStop (
    .clk(clk), .reset(reset), .ena_i(pnl.ena), .din_i(cond[1]), .dout_o(dStop)
  );

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebAuto (
    .clk(clk), .reset(reset), .ena_i(pnl.ena), .din_i(cond[2]), .dout_o(dAuto)
  );

  panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebMan (
    .clk(clk), .reset(reset), .ena_i(pnl.ena), .din_i(cond[3]), .dout_o(dMan)
  );

  logic startPrev_q, stopPrev_q;
  logic startRise, stopRise;

  // Previous debounced button levels for edge detection, frozen with ena.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startPrev_q <= 1'b0;
      stopPrev_q  <= 1'b0;
    end else if (pnl.ena) begin
      startPrev_q <= dStart;
      stopPrev_q  <= dStop;
    end
  end

  assign startRise = dStart & ~startPrev_q;
  assign stopRise  = dStop & ~stopPrev_q;

  logic autoValid, manValid, modeChange;
  logic auto_q, man_q;

  // A mode is valid only when its contact is the sole one made.
  assign autoValid  = dAuto & ~dMan;
  assign manValid   = dMan & ~dAuto;
  assign modeChange = (autoValid != auto_q) || (manValid != man_q);

  // Registered mode outputs; follow the debounced selector while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_q <= 1'b0;
      man_q  <= 1'b0;
    end else if (pnl.ena) begin
      auto_q <= autoValid;
      man_q  <= manValid;
    end
  end

  panel_state_e state_q, state_d;
  logic         start_q, start_d;
  logic         fault_q, fault_d;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: e-stop wins regardless of ena, otherwise ena gates all moves.
  always_comb begin
    state_d = state_q;
    if (estopAct) begin
      state_d = ST_FAULT;
    end else if (pnl.ena) begin
      case (state_q)
        ST_IDLE: begin
          if (startRise && (autoValid || manValid) && !dStop) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (dStop || modeChange) begin
            state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (stopRise) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the flops line up with state_q.
  always_comb begin
    start_d = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  // Registered start/fault outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      start_q <= start_d;
      fault_q <= fault_d;
    end
  end

  assign pnl.start_o = start_q;
  assign pnl.fault_o = fault_q;
  assign pnl.auto_o  = auto_q;
  assign pnl.man_o   = man_q;
  assign pnl.state_o = state_q;

endmodule

// File: tb/tb_lathe_panel_cond.sv
// Directed bench for lathe_panel_cond with DEBOUNCE_CYCLES=4; latency
// expectations follow PANEL_SYNC_EN when it is defined.
module tb_lathe_panel_cond;

`ifdef PANEL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lathe_panel_cond_if pif ();

  lathe_panel_cond #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .pnl(pif)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs packed as {start, auto, man, fault, state[1:0]}.
  function automatic logic [5:0] outs();
    return {pif.start_o, pif.auto_o, pif.man_o, pif.fault_o, pif.state_o};
  endfunction

  task automatic applyStimulus(input logic start, input logic stop, input logic selA,
                               input logic selM, input logic estopN);
    pif.btn_start = start;
    pif.btn_stop  = stop;
    pif.sel_auto  = selA;
    pif.sel_man   = selM;
    pif.estop_n   = estopN;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    pif.ena = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       selA;
    logic       selM;
    logic       estopN;
    int         hold;
    logic [5:0] expOut;
  } vec_t;

  vec_t vecs [15];

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic sawHigh;
    logic prevStart;
    logic found;
    int   firstHigh;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;

    // Steady-state vectors; each starts from the state the previous left.
    //              start stop  auto  man   estN  hold  {st,au,mn,ft,state}
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10, 6'b010000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10, 6'b110001};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10, 6'b110001};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10, 6'b010000};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10, 6'b010000};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10, 6'b110001};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10, 6'b000000};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10, 6'b000000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10, 6'b001000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10, 6'b101001};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  4, 6'b001110};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10, 6'b001110};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10, 6'b001110};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10, 6'b001000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10, 6'b001000};

    resetDut();
    @(negedge clk);
    checkOutput("resetState", outs(), 6'b000000);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].selA, vecs[i].selM, vecs[i].estopN);
      repeat (vecs[i].hold) @(negedge clk);
      checkOutput($sformatf("vec%0d", i), outs(), vecs[i].expOut);
    end

    // Short start pulse is filtered, long one starts after sync+debounce+1.
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    sawHigh = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (pif.start_o) sawHigh = 1'b1;
    end
    checkOutput("shortPulse", sawHigh, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    firstHigh = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (pif.start_o && firstHigh == 0) firstHigh = k;
      if (k == 8) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    checkOutput("longPulseLatency", firstHigh, SYNC_LAT + 5);
    repeat (10) @(negedge clk);

    // Stop while start is held drops to IDLE and stays there.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (22) @(negedge clk);
    checkOutput("stopWithStartHeld", outs(), 6'b010000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // One-cycle e-stop from RUN, start ignored in FAULT, stop acknowledges.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("runBeforeEstop", outs(), 6'b110001);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= SYNC_LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (k == SYNC_LAT) checkOutput("estopNotYet", outs(), 6'b110001);
    end
    checkOutput("estopFault", outs(), 6'b010110);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("faultIgnoresStart", outs(), 6'b010110);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("faultAck", outs(), 6'b010000);

    // ena low freezes start handling but e-stop still trips FAULT.
    pif.ena = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("enaLowHold", outs(), 6'b010000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("enaLowEstop", outs(), 6'b010110);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    pif.ena = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("enaEstopAck", outs(), 6'b010000);

    // RUN in MAN, selector moved to AUTO: start drops with man_o.
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("manRun", outs(), 6'b101001);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    prevStart = pif.start_o;
    found = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (!found && !pif.man_o) begin
        found = 1'b1;
        checkOutput("selectorSwitch", {pif.start_o, prevStart}, 2'b01);
      end
      prevStart = pif.start_o;
    end
    checkOutput("selectorSwitchSeen", found, 1);

    // Reset asserted mid-RUN clears outputs without waiting for a clock.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("autoRun", outs(), 6'b110001);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("asyncReset", outs(), 6'b000000);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lathe_panel_cond.md
LATHE_PANEL_COND -- requirements
Module: lathe_panel_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive enabled cycles an input must be stable before its debounced value changes (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ena  input  1  clock enable; low freezes all state except e-stop handling.
REQ-005 SHALL have port btn_start  input  1  raw start push-button, active high.
REQ-006 SHALL have port btn_stop  input  1  raw stop push-button, active high.
REQ-007 SHALL have port sel_auto  input  1  raw AUTO selector contact.
REQ-008 SHALL have port sel_man  input  1  raw MAN selector contact.
REQ-009 SHALL have port estop_n  input  1  raw emergency stop, active low.
REQ-010 SHALL have port start_o  output  1  sealed-in start level to the delay/control stage.
REQ-011 SHALL have port auto_o  output  1  clean AUTO mode level.
REQ-012 SHALL have port man_o  output  1  clean MAN mode level.
REQ-013 SHALL have port fault_o  output  1  high while in FAULT.
REQ-014 SHALL have port state_o  output  2  FSM state encoding: IDLE=0, RUN=1, FAULT=2.

Function
REQ-015 SHALL debounce btn_start, btn_stop, sel_auto and sel_man independently: per-input counter clears when the sampled input equals the debounced value, else increments; debounced value toggles on the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter clears.
REQ-016 SHALL not debounce estop_n; e-stop acts on its (optionally synchronised) value on the next clock, independent of ena.
REQ-017 SHALL drive auto_o=1 only when debounced AUTO=1 and MAN=0; man_o=1 only when MAN=1 and AUTO=0; both 0 on conflict or neither selected.
REQ-018 SHALL implement FSM IDLE/RUN/FAULT; outputs are registered; start_o=1 exactly in RUN.
REQ-019 IDLE->RUN SHALL occur one cycle after a debounced start rising edge when exactly one mode is valid, debounced stop=0 and e-stop inactive; otherwise the edge is discarded (no memory).
REQ-020 RUN->IDLE SHALL occur one cycle after debounced stop=1, or when auto_o/man_o changes value.
REQ-021 Any state->FAULT SHALL occur one cycle after e-stop active; FAULT has priority over all other transitions.
REQ-022 FAULT->IDLE SHALL require e-stop inactive AND a debounced stop rising edge (operator acknowledge); a start edge in FAULT is ignored.
REQ-023 Simultaneous debounced start and stop edges in IDLE SHALL leave the FSM in IDLE.
REQ-024 Holding start continuously SHALL not re-enter RUN after a stop; a fresh start rising edge is required.
REQ-025 ena low SHALL hold counters, debounced values and the FSM, except REQ-021.

Reset
REQ-026 reset SHALL asynchronously force FSM=IDLE, all outputs 0, all counters 0, all debounced values 0, synchroniser flops 0.
REQ-027 Reset deasserted mid-press SHALL require a full debounce interval before the input is recognised.

Configuration
REQ-028 With PANEL_SYNC_EN defined, each raw input SHALL pass through a 2-flop synchroniser before debounce/e-stop logic (latency +2 cycles).
REQ-029 Without PANEL_SYNC_EN, raw inputs SHALL feed the debouncers and e-stop logic directly.

Structure
REQ-030 A shared package panel_pkg SHALL hold the FSM state typedef/encodings and the DEBOUNCE_CYCLES default constant.
REQ-031 One sub-module panel_debounce (1-bit input, counter, debounced output, ena) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, PANEL_SYNC_EN defined)
REQ-032 sel_auto=1 held, btn_start pulse of 3 cycles -> start_o stays 0; pulse of 8 cycles -> start_o=1 exactly 2+4+1 cycles after the press begins.
REQ-033 RUN in AUTO, btn_stop held 6 cycles -> start_o=0, state_o=0; start held throughout does not re-enter RUN.
REQ-034 RUN, estop_n=0 for 1 cycle -> fault_o=1, state_o=2 three cycles later; start press ignored; estop_n=1 then stop press -> state_o=0.
REQ-035 sel_auto=1 and sel_man=1 -> auto_o=man_o=0, start press leaves state_o=0.
REQ-036 RUN in MAN, switch selector to AUTO -> start_o=0 when man_o falls; reset asserted mid-RUN -> all outputs 0 immediately.
